// File: rtl/clock_setter.sv
// Set-mode controller: debounced buttons drive the RUN/SET_* sequence
// and hand inc_* request levels to the 1 Hz time-of-day counter.

module clock_setter_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module clock_setter_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;
  logic         state;

  // the counter only runs while the input disagrees with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        state <= level;
        press <= level;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

module clock_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_TICKS   = 10
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

  logic tick_s;
  logic tick_d;
  logic mode_s;
  logic up_s;
  logic tick_rise;
  logic tick_fall;
  logic mode_press;
  logic up_press;

  state_t     state;
  state_t     state_nxt;
  state_t     state_adv;
  logic [7:0] to_cnt;
  logic [7:0] to_nxt;
  // bit 0 = hour, bit 1 = min, bit 2 = sec
  logic [2:0] pend;
  logic [2:0] pend_nxt;
  logic [2:0] arm;
  logic [2:0] arm_nxt;
  logic [2:0] up_sel;

  clock_setter_sync u_sync_tick (
    .clk (clk_100MHz),
    .rst (reset),
    .d   (tick_1Hz),
    .q   (tick_s)
  );

  clock_setter_sync u_sync_mode (
    .clk (clk_100MHz),
    .rst (reset),
    .d   (btn_mode),
    .q   (mode_s)
  );

  clock_setter_sync u_sync_up (
    .clk (clk_100MHz),
    .rst (reset),
    .d   (btn_up),
    .q   (up_s)
  );

  clock_setter_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_mode (
    .clk   (clk_100MHz),
    .rst   (reset),
    .level (mode_s),
    .press (mode_press)
  );

  clock_setter_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk   (clk_100MHz),
    .rst   (reset),
    .level (up_s),
    .press (up_press)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) tick_d <= 1'b0;
    else       tick_d <= tick_s;
  end

  assign tick_rise = tick_s & ~tick_d;
  assign tick_fall = ~tick_s & tick_d;

  always_comb begin
    state_adv = RUN;
    up_sel    = 3'b000;
    unique case (state)
      RUN: begin
        state_adv = SET_HOUR;
        up_sel    = 3'b000;
      end
      SET_HOUR: begin
        state_adv = SET_MIN;
        up_sel    = 3'b001;
      end
      SET_MIN: begin
        state_adv = SET_SEC;
        up_sel    = 3'b010;
      end
      SET_SEC: begin
        state_adv = RUN;
        up_sel    = 3'b100;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    pend_nxt  = pend;
    arm_nxt   = arm;

    if (tick_fall) begin
      arm_nxt  = pend;
      pend_nxt = 3'b000;
    end
    if (tick_rise) arm_nxt = 3'b000;

    // one request per field: drop presses while one is queued or armed
    if (up_press) pend_nxt = pend_nxt | (up_sel & ~pend & ~arm);

    if (mode_press || up_press) begin
      to_nxt = 8'd0;
    end else if (tick_rise && state != RUN) begin
      if (to_cnt == TO_LAST) state_nxt = RUN;
      else                   to_nxt    = to_cnt + 8'd1;
    end

    if (mode_press) state_nxt = state_adv;

    // armed requests survive a mode change, queued ones do not
    if (state_nxt != state) begin
      pend_nxt = 3'b000;
      to_nxt   = 8'd0;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      to_cnt <= 8'd0;
      pend   <= 3'b000;
      arm    <= 3'b000;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_nxt;
      pend   <= pend_nxt;
      arm    <= arm_nxt;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      inc_sec  <= 1'b0;
      inc_min  <= 1'b0;
      inc_hour <= 1'b0;
      blink    <= 1'b0;
    end else begin
      inc_sec  <= (state == RUN) | arm[2];
      inc_min  <= arm[1];
      inc_hour <= arm[0];
      blink    <= (state != RUN) & tick_s;
    end
  end

  assign mode = state;

endmodule
